// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: valid/ready write port, on-chip baud divider,
// configurable data/stop bits. Define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`else
    logic                 unused_parity;
    assign unused_parity = (PARITY_ODD != 0);
`endif

    assign tx_ready   = (count_q != FULL_CNT);
    assign fifo_count = count_q;
    assign tx_busy    = (count_q != '0) || (state_q != IDLE);
    assign uart_tx    = tx_q;
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        pop     = 1'b0;
        bit_end = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        stop_d  = 1'b0;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    div_d   = '0;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    if (stop_q == STOP_LAST) begin
                        // Chain straight into the next frame when data is waiting
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = head;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (pop) begin
            par_d = (^head) ^ (PARITY_ODD != 0);
        end
    end
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Line is driven from the registered state, so it trails the FSM by one cycle
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the single-byte serial sender. It adds a configurable data width, a stop-bit count and an on-chip baud divider, and replaces the single holding register with a write FIFO under a valid/ready handshake. It sits between the CPU's memory-mapped serial port register and the board TX pin. One clock domain.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..8.
BAUD_DIV, 16, clk cycles per bit period; legal range ≥2.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, ≥2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset. Logic is reset when reset==0 at a rising edge of clk.
tx_data  input  DATA_BITS  byte to enqueue.
tx_valid  input  1  write request; qualified by tx_ready.
tx_ready  output  1  high when the FIFO is not full.
uart_tx  output  1  serial line; registered; idles high.
tx_busy  output  1  high when the FIFO is non-empty or a frame is in progress.
fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (reset==0 at clk edge): uart_tx=1, tx_ready=1, tx_busy=0, fifo_count=0. FSM goes to IDLE, the divider and bit counters clear, and FIFO pointers clear.
- Reset mid-frame aborts the frame and discards FIFO contents. The line returns high on the next cycle.
- Enqueue: on a clk edge with tx_valid && tx_ready, tx_data is written at the write pointer. With tx_valid && !tx_ready the write is dropped and no state changes. tx_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
- Dequeue happens only in IDLE or at the end of the final stop bit, when the FIFO is non-empty. The head word is loaded into the shift register in the same cycle as the pop.
- Simultaneous push and pop leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop and go to START.
  - START: uart_tx=0 for BAUD_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each held BAUD_DIV cycles. The bit index counts 0..DATA_BITS-1.
  - PARITY: one bit period.
  - STOP: uart_tx=1 for STOP_BITS×BAUD_DIV cycles. At the last cycle of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Divider: counter 0..BAUD_DIV-1, cleared on every state entry. A bit boundary occurs when the counter reaches BAUD_DIV-1.
- Latency: a word accepted at edge N into an empty FIFO while in IDLE is popped at edge N+1. uart_tx goes low at edge N+2.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)×BAUD_DIV cycles, where P is 1 with parity compiled in and 0 without.
- uart_tx and all state outputs are glitch-free registered values. tx_busy is combinational: (fifo_count != 0) || (state != IDLE).
- tx_data is sampled only at enqueue; changes on tx_data afterwards do not affect queued words.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: the PARITY state is inserted between DATA and STOP. The parity bit is the XOR of the DATA_BITS payload bits, inverted when PARITY_ODD=1.
- Not defined: no parity logic is present, the PARITY_ODD parameter is ignored, and DATA goes directly to STOP.

Test Plan:
- Default parameters, parity off. Reset, then write 0xA5 at edge N → uart_tx low at N+2. The line carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_busy drops at the end of the stop bit. Total frame 160 cycles.
- Burst of 5 writes (0x01..0x05) with FIFO_DEPTH=4 while idle. The first pops at once, so all 5 are accepted: tx_ready deasserts only when fifo_count=4. The frames are sent back-to-back with no idle cycles between the stop bit and the next start bit.
- Fill the FIFO and hold tx_valid high with 0xFF while tx_ready=0 → the dropped word never appears on the line. fifo_count stays at 4 until the next pop.
- DATA_BITS=7, STOP_BITS=2, BAUD_DIV=4, UART_TX_PARITY_EN with PARITY_ODD=1. Write 0x55 → line carries start 0, data 1010101, parity 1, stop 1,1. Each bit lasts 4 cycles; total 44 cycles.
- Assert reset low during the 3rd data bit with 2 words queued → uart_tx=1 the next cycle, fifo_count=0, tx_busy=0. No further frames follow after reset is released.
- Simultaneous push and pop at the stop-to-start boundary → fifo_count unchanged. Word order on the line is preserved across pointer wrap for 10 consecutive words.
